// File: rtl/operand_scoreboard_pkg.sv
// Shared ISA constants and state encoding for the decode-stage operand scoreboard.
package operand_scoreboard_pkg;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 27;
    localparam int RD_HI    = 26;
    localparam int RD_LO    = 22;
    localparam int RS_HI    = 21;
    localparam int RS_LO    = 17;
    localparam int RT_HI    = 16;
    localparam int RT_LO    = 12;
    localparam int ALUOP_HI = 6;
    localparam int ALUOP_LO = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/operand_scoreboard_decode.sv
// Opcode-aware register index extraction; branches, sw and jr read rd on port B.
module operand_decode
    import operand_scoreboard_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int STATUS_REG = 30,
    parameter int LINK_REG   = 31
) (
    input  logic [31:0]      instruction,
    output logic [REG_W-1:0] rs1,
    output logic [REG_W-1:0] rs2,
    output logic [REG_W-1:0] rd_wr,
    output logic             reads_rs1,
    output logic             reads_rs2,
    output logic             is_multdiv
);

    logic [4:0]       opcode;
    logic [4:0]       aluop;
    logic [REG_W-1:0] f_rd;
    logic [REG_W-1:0] f_rs;
    logic [REG_W-1:0] f_rt;
    logic             unused_bits;

    assign opcode      = instruction[OPC_HI:OPC_LO];
    assign aluop       = instruction[ALUOP_HI:ALUOP_LO];
    assign f_rd        = REG_W'(instruction[RD_HI:RD_LO]);
    assign f_rs        = REG_W'(instruction[RS_HI:RS_LO]);
    assign f_rt        = REG_W'(instruction[RT_HI:RT_LO]);
    assign unused_bits = ^{instruction[11:7], instruction[1:0]};

    always_comb begin
        rs1       = f_rs;
        rs2       = f_rt;
        rd_wr     = '0;
        reads_rs2 = 1'b0;
        case (opcode)
            OP_ALU: begin
                rd_wr     = f_rd;
                reads_rs2 = 1'b1;
            end
            OP_ADDI, OP_LW: rd_wr = f_rd;
            OP_BNE, OP_BLT, OP_SW, OP_JR: begin
                rs2       = f_rd;
                reads_rs2 = 1'b1;
            end
            OP_J:   rs1 = '0;
            OP_JAL: begin
                rs1   = '0;
                rd_wr = REG_W'(LINK_REG);
            end
            OP_SETX: begin
                rs1   = '0;
                rd_wr = REG_W'(STATUS_REG);
            end
            OP_BEX: rs1 = REG_W'(STATUS_REG);
            default: ;
        endcase
    end

    assign reads_rs1  = (rs1 != '0);
    assign is_multdiv = (opcode == OP_ALU) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));

endmodule

// File: rtl/operand_scoreboard.sv
// Decode-stage operand unit with a single-entry multdiv scoreboard and hang detector.
// Optional macro OPSB_MD_BYPASS_EN releases dependents in the md_done cycle itself.
module operand_scoreboard
    import operand_scoreboard_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int CNT_W      = 6,
    parameter int MD_TIMEOUT = 40,
    parameter int STATUS_REG = 30,
    parameter int LINK_REG   = 31
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fd_valid,
    input  logic [31:0]      instruction,
    input  logic             flush,
    input  logic             md_done,
    output logic [REG_W-1:0] rs1,
    output logic [REG_W-1:0] rs2,
    output logic [REG_W-1:0] rd_wr,
    output logic             stall,
    output logic             issue,
    output logic             md_busy,
    output logic [REG_W-1:0] md_rd,
    output logic [CNT_W-1:0] md_cycles,
    output logic             md_timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_HANG = CNT_W'(MD_TIMEOUT - 1);

    logic             reads_rs1;
    logic             reads_rs2;
    logic             is_multdiv;
    logic             dep_hit;
    logic             hazard;
    logic             md_start;

    md_state_t        state;
    md_state_t        state_nxt;
    logic [REG_W-1:0] md_rd_nxt;
    logic [CNT_W-1:0] md_cycles_nxt;
    logic             md_timeout_nxt;

    operand_decode #(
        .REG_W      (REG_W),
        .STATUS_REG (STATUS_REG),
        .LINK_REG   (LINK_REG)
    ) u_decode (
        .instruction (instruction),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd_wr       (rd_wr),
        .reads_rs1   (reads_rs1),
        .reads_rs2   (reads_rs2),
        .is_multdiv  (is_multdiv)
    );

    // md_rd == 0 marks a result nobody can depend on; only the structural hazard remains.
    assign dep_hit = is_multdiv
                   || ((md_rd != '0) && ((reads_rs1 && (rs1 == md_rd))
                                      || (reads_rs2 && (rs2 == md_rd))
                                      || (rd_wr == md_rd)));

`ifdef OPSB_MD_BYPASS_EN
    assign hazard = fd_valid && md_busy && !md_done && dep_hit;
`else
    assign hazard = fd_valid && md_busy && dep_hit;
`endif

    assign stall    = hazard && !flush;
    assign issue    = fd_valid && !stall && !flush;
    assign md_start = issue && is_multdiv;
    assign md_busy  = (state == ST_BUSY);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            md_rd      <= '0;
            md_cycles  <= '0;
            md_timeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            md_rd      <= md_rd_nxt;
            md_cycles  <= md_cycles_nxt;
            md_timeout <= md_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        md_rd_nxt      = md_rd;
        md_cycles_nxt  = md_cycles;
        md_timeout_nxt = md_timeout || (md_busy && (md_cycles == CNT_HANG) && !md_done);
        case (state)
            ST_IDLE: begin
                if (md_start) begin
                    state_nxt     = ST_BUSY;
                    md_rd_nxt     = rd_wr;
                    md_cycles_nxt = '0;
                end
            end
            ST_BUSY: begin
                // A new multdiv issuing alongside md_done takes over the entry.
                if (md_start) begin
                    md_rd_nxt     = rd_wr;
                    md_cycles_nxt = '0;
                end else if (md_done) begin
                    state_nxt     = ST_IDLE;
                    md_rd_nxt     = '0;
                    md_cycles_nxt = '0;
                end else if (md_cycles != CNT_MAX) begin
                    md_cycles_nxt = md_cycles + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: doc/operand_scoreboard.md
# operand_scoreboard

Parametrised decode-stage operand unit: extracts source/destination register indices from the instruction in F/D (opcode-aware: branches, sw, and jr read rd as a source). It also tracks a single outstanding multi-cycle mult/div writeback in a scoreboard. It generates the F/D stall and issue signals so dependent instructions wait for the multdiv result, and it flags multdiv operations that never complete. It sits between the F/D latch and the D/X latch and feeds the register file read ports.

## Interface
- REG_W, 5, register index width; NUM_REGS = 2**REG_W
- CNT_W, 6, width of the multdiv cycle counter
- MD_TIMEOUT, 40, cycle count at which an outstanding multdiv is declared hung
- STATUS_REG, 30, register written by setx and read by bex
- LINK_REG, 31, register written by jal
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- fd_valid  in  1  F/D latch holds a valid instruction
- instruction  in  32  F/D instruction: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], aluop[6:2]
- flush  in  1  branch/jump squash of the F/D instruction this cycle
- md_done  in  1  multdiv unit is writing back its result this cycle
- rs1  out  REG_W  read port A index
- rs2  out  REG_W  read port B index
- rd_wr  out  REG_W  destination index; 0 if the instruction writes nothing
- stall  out  1  hold PC and F/D, insert bubble into D/X
- issue  out  1  fd_valid & ~stall & ~flush
- md_busy  out  1  a multdiv is outstanding
- md_rd  out  REG_W  destination of the outstanding multdiv
- md_cycles  out  CNT_W  cycles since the outstanding multdiv issued (saturating)
- md_timeout  out  1  sticky hang flag

## Operation
- Decode is combinational:
  - rs2 = rd for bne(00010), blt(00110), sw(00111), jr(00100); otherwise rt.
  - rs1 = STATUS_REG for bex(10110); 0 for j, jal, setx; otherwise rs.
  - rd_wr = rd for ALU(00000), addi, lw; LINK_REG for jal; STATUS_REG for setx; 0 otherwise.
- Read usage: reads_rs1 is set when rs1 != 0. reads_rs2 is set for ALU R-type, bne, blt, sw, jr.
- Multdiv instruction: opcode 00000 with aluop 00110 (mul) or 00111 (div).
- Hazard exists when fd_valid & md_busy & ~md_done and any of:
  - rs1 == md_rd with reads_rs1
  - rs2 == md_rd with reads_rs2
  - rd_wr == md_rd (WAW)
  - the instruction is a multdiv (structural)
- md_rd == 0 matches no register compare; the structural hazard still applies.
- stall = hazard & ~flush.
- State: IDLE (md_busy=0) and BUSY (md_busy=1).
  - IDLE -> BUSY on issue of a multdiv: md_rd <= rd, md_cycles <= 0.
  - BUSY: md_cycles increments each cycle, saturating at 2**CNT_W-1.
  - BUSY -> IDLE on md_done.
  - md_done together with issue of a new multdiv stays in BUSY and reloads md_rd/md_cycles; the set wins over the clear.
- md_timeout sets when md_busy & md_cycles == MD_TIMEOUT-1 & ~md_done. It clears only on reset.
- flush suppresses issue, so a flushed multdiv never enters BUSY. flush never cancels an outstanding multdiv.

## Timing
- Reset values: md_busy 0, md_rd 0, md_cycles 0, md_timeout 0. stall and issue follow their combinational inputs.
- Decode outputs and stall have zero latency (same cycle as instruction).
- With the bypass feature off, a dependent instruction stalls through the md_done cycle and issues the cycle after.
- Reset asserted mid-BUSY returns to IDLE immediately, without waiting for a clock edge.

## Configuration
- OPSB_MD_BYPASS_EN defined: in the md_done cycle the RAW compares against md_rd are masked, so a dependent instruction issues in that same cycle. The writeback value is forwarded externally. The WAW and structural hazards are also released in that cycle.
- Not defined: hazard ignores md_done for all compares, so the release happens one cycle later.

## Structure
- Shared package holds:
  - opcode constants: OP_ALU, OP_J, OP_BNE, OP_JAL, OP_JR, OP_ADDI, OP_BLT, OP_SW, OP_LW, OP_SETX, OP_BEX
  - ALU op constants: ALU_MUL, ALU_DIV
  - instruction field bit positions
- One sub-module, operand_decode: the combinational production of rs1, rs2, rd_wr, the read-usage flags and is_multdiv. The scoreboard FSM stays in the top level.

## Test plan
- mul $5,$2,$3 issues; next instruction add $6,$5,$1 -> stall=1 until md_done. Released in the md_done cycle with OPSB_MD_BYPASS_EN defined, the cycle after without it.
- sw $5,0($4) while md_rd=5 -> rs2=5, stall=1 (sw reads rd). While md_rd=7 -> stall=0, issue=1.
- bex with md_rd=30 -> rs1=30, stall=1. jal with md_rd=31 -> rd_wr=31, stall=1 (WAW).
- Second div while busy -> stall=1. md_done in the same cycle as a new mul issuing (bypass build) -> md_busy stays 1, md_rd becomes the new rd, md_cycles=0.
- mul with rd=0 -> md_busy=1 and add $1,$0,$0 does not stall. A flushed mul (flush=1) -> issue=0 and md_busy stays 0.
- No md_done for 40 cycles after issue -> md_timeout=1 from cycle 40, held after md_done. Reset mid-BUSY -> all registered outputs 0 immediately.
